// File: rtl/uart_frame_assembler.sv
// Collects strobed bytes into a frame ended by 0xBE 0xEF (UART) or 0x0D (BLE).
// Idle-timeout detection is built only when UART_FRAME_ASSEMBLER_TIMEOUT_EN is defined.
module uart_frame_assembler #(
    parameter  int unsigned MAX_BYTES = 128,
    parameter  int unsigned TIMEOUT   = 1026,
    localparam int unsigned SIZE_W    = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             input_data,
    input  logic                   accumulate,
    input  logic                   ble_side,
    input  logic                   ack,
    output logic [8*MAX_BYTES-1:0] output_data,
    output logic [SIZE_W-1:0]      output_data_size,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             error_code
);
    localparam logic [7:0]      BYTE_BE       = 8'hBE;
    localparam logic [7:0]      BYTE_EF       = 8'hEF;
    localparam logic [7:0]      BYTE_CR       = 8'h0D;
    localparam logic [1:0]      CODE_TIMEOUT  = 2'b01;
    localparam logic [1:0]      CODE_OVERFLOW = 2'b10;
    localparam logic [SIZE_W:0] MAX_CNT       = (SIZE_W + 1)'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_PEND_BE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic            acc_q, mode_q;
    logic            byte_edge_c, mode_c, tmo_hit_c;
    logic            store_one_c, store_pair_c, clear_c, set_code_c;
    logic [1:0]      code_c;
    logic [SIZE_W:0] size_c, size_p1_c, size_p2_c;

    assign byte_edge_c = accumulate & ~acc_q;
    // The first byte of a frame is interpreted with the live ble_side; later bytes use the latched mode.
    assign mode_c      = (state_q == S_IDLE) ? ble_side : mode_q;
    assign size_c      = {1'b0, output_data_size};
    assign size_p1_c   = size_c + (SIZE_W + 1)'(1);
    assign size_p2_c   = size_c + (SIZE_W + 1)'(2);

`ifdef UART_FRAME_ASSEMBLER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_run_c;

    assign tmo_run_c = (state_q == S_ACCUM) || (state_q == S_PEND_BE);
    assign tmo_hit_c = tmo_run_c && (tmo_q == TMO_W'(TIMEOUT));

    // Clocks since the last accepted byte; only runs while a frame is open.
    always_ff @(posedge clk) begin
        if (reset || byte_edge_c || !tmo_run_c) begin
            tmo_q <= '0;
        end else if (!tmo_hit_c) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    // No timeout; TIMEOUT stays in the parameter list so both builds share one interface.
    assign tmo_hit_c = (TIMEOUT == 0) & 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        store_one_c  = 1'b0;
        store_pair_c = 1'b0;
        clear_c      = 1'b0;
        set_code_c   = 1'b0;
        code_c       = CODE_OVERFLOW;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (byte_edge_c) begin
                    if (!mode_c && input_data == BYTE_BE) begin
                        state_d = S_PEND_BE;
                    end else if (mode_c && input_data == BYTE_CR) begin
                        state_d = S_DONE;
                    end else if (size_p1_c > MAX_CNT) begin
                        state_d    = S_ERROR;
                        set_code_c = 1'b1;
                    end else begin
                        state_d     = S_ACCUM;
                        store_one_c = 1'b1;
                    end
                end else if (tmo_hit_c) begin
                    state_d    = S_ERROR;
                    set_code_c = 1'b1;
                    code_c     = CODE_TIMEOUT;
                end
            end
            // A held 0xBE is committed only once its successor shows it was not a terminator.
            S_PEND_BE: begin
                if (byte_edge_c) begin
                    if (input_data == BYTE_EF) begin
                        state_d = S_DONE;
                    end else if (input_data == BYTE_BE) begin
                        if (size_p1_c > MAX_CNT) begin
                            state_d    = S_ERROR;
                            set_code_c = 1'b1;
                        end else begin
                            store_one_c = 1'b1;
                        end
                    end else if (size_p2_c > MAX_CNT) begin
                        state_d    = S_ERROR;
                        set_code_c = 1'b1;
                    end else begin
                        state_d      = S_ACCUM;
                        store_pair_c = 1'b1;
                    end
                end else if (tmo_hit_c) begin
                    state_d    = S_ERROR;
                    set_code_c = 1'b1;
                    code_c     = CODE_TIMEOUT;
                end
            end
            S_DONE, S_ERROR: begin
                if (ack) begin
                    state_d = S_IDLE;
                    clear_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= 1'b0;
            mode_q <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
        end else begin
            acc_q <= accumulate;
            if (state_q == S_IDLE && byte_edge_c) begin
                mode_q <= ble_side;
            end
            done  <= (state_d == S_DONE);
            error <= (state_d == S_ERROR);
        end
    end

    // Payload store: one byte, or the held 0xBE plus the current byte, at the current size.
    always_ff @(posedge clk) begin
        if (reset || clear_c) begin
            output_data      <= '0;
            output_data_size <= '0;
            error_code       <= 2'b00;
        end else begin
            if (set_code_c) begin
                error_code <= code_c;
            end
            if (store_one_c) begin
                output_data_size <= size_p1_c[SIZE_W-1:0];
            end else if (store_pair_c) begin
                output_data_size <= size_p2_c[SIZE_W-1:0];
            end
            for (int k = 0; k < int'(MAX_BYTES); k++) begin
                if (store_one_c && (SIZE_W + 1)'(k) == size_c) begin
                    output_data[8*k +: 8] <= input_data;
                end
                if (store_pair_c && (SIZE_W + 1)'(k) == size_c) begin
                    output_data[8*k +: 8] <= BYTE_BE;
                end
                if (store_pair_c && (SIZE_W + 1)'(k) == size_p1_c) begin
                    output_data[8*k +: 8] <= input_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Bench for uart_frame_assembler: directed frames plus randomized frames scored
// against a terminator-search reference model.
module tb_uart_frame_assembler;
    localparam int unsigned MB  = 128;
    localparam int unsigned TMO = 1026;
    localparam int unsigned SW  = $clog2(MB + 1);
    localparam int unsigned DW  = 8 * MB;

    typedef logic [7:0] bytes_t[$];

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    input_data;
    logic          accumulate;
    logic          ble_side;
    logic          ack;
    logic [DW-1:0] output_data;
    logic [SW-1:0] output_data_size;
    logic          done;
    logic          error;
    logic [1:0]    error_code;

    int n_checks = 0;
    int n_pass   = 0;

    uart_frame_assembler #(.MAX_BYTES(MB), .TIMEOUT(TMO)) dut (
        .clk              (clk),
        .reset            (reset),
        .input_data       (input_data),
        .accumulate       (accumulate),
        .ble_side         (ble_side),
        .ack              (ack),
        .output_data      (output_data),
        .output_data_size (output_data_size),
        .done             (done),
        .error            (error),
        .error_code       (error_code)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Expected outcome from the frame rules: payload is everything before the first
    // terminator; a frame whose payload would pass MB bytes ends in overflow.
    function automatic void model(input logic mode, input bytes_t b,
                                  output logic e_done, output logic e_err,
                                  output logic [1:0] e_code, output int e_size,
                                  output logic [DW-1:0] e_data);
        int term;
        int n;
        term = -1;
        for (int i = 0; i < b.size(); i++) begin
            if (mode ? (b[i] == 8'h0D)
                     : (i + 1 < b.size() && b[i] == 8'hBE && b[i+1] == 8'hEF)) begin
                term = i;
                break;
            end
        end
        e_done = 1'b0;
        e_err  = 1'b0;
        e_code = 2'b00;
        e_data = '0;
        if (term >= 0 && term <= int'(MB)) begin
            e_done = 1'b1;
            n = term;
        end else if (b.size() > int'(MB)) begin
            // A trailing 0xBE is only committed with its successor; a pair that cannot fit is refused.
            e_err  = 1'b1;
            e_code = 2'b10;
            n = int'(MB);
            if (!mode && b[MB-1] == 8'hBE && b[MB] != 8'hBE) n = int'(MB) - 1;
        end else begin
            n = b.size();
        end
        e_size = n;
        for (int k = 0; k < n; k++) e_data[8*k +: 8] = b[k];
    endfunction

    function automatic logic [7:0] rand_byte(input int special_pct);
        int r;
        r = $urandom_range(0, 99);
        if (r < special_pct) begin
            case ($urandom_range(0, 2))
                0:       return 8'hBE;
                1:       return 8'hEF;
                default: return 8'h0D;
            endcase
        end
        return 8'($urandom);
    endfunction

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        input_data = b;
        accumulate = 1'b1;
        repeat (hold - 1) @(negedge clk);
        @(negedge clk);
        accumulate = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_done"}, DW'(done), DW'(0));
        check({tag, "_error"}, DW'(error), DW'(0));
        check({tag, "_code"}, DW'(error_code), DW'(0));
        check({tag, "_size"}, DW'(output_data_size), DW'(0));
        check({tag, "_data"}, output_data, '0);
    endtask

    task automatic do_ack(input bit with_strobe);
        @(negedge clk);
        ack = 1'b1;
        if (with_strobe) begin
            input_data = 8'h33;
            accumulate = 1'b1;
        end
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        accumulate = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic mode, input bytes_t b, input bit rnd);
        logic          ed, ee;
        logic [1:0]    ec;
        int            es;
        logic [DW-1:0] edat;
        model(mode, b, ed, ee, ec, es, edat);
        ble_side = mode;
        foreach (b[i]) begin
            if (rnd && i > 0) ble_side = 1'($urandom_range(0, 1));
            send_byte(b[i], rnd ? $urandom_range(1, 3) : 1);
            if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        check({tag, "_done"}, DW'(done), DW'(ed));
        check({tag, "_error"}, DW'(error), DW'(ee));
        check({tag, "_code"}, DW'(error_code), DW'(ec));
        check({tag, "_size"}, DW'(output_data_size), DW'(es));
        check({tag, "_data"}, output_data, edat);
    endtask

    initial begin
        bytes_t        b;
        logic [DW-1:0] exp;
        logic          m;
        int            len;
        int            sp;
        int            waited;

        reset      = 1'b1;
        input_data = 8'h00;
        accumulate = 1'b0;
        ble_side   = 1'b0;
        ack        = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        b.delete();
        repeat (10) b.push_back(8'h27);
        b.push_back(8'hBE);
        b.push_back(8'hEF);
        run_frame("uart10", 1'b0, b, 1'b0);
        exp = '0;
        for (int k = 0; k < 10; k++) exp[8*k +: 8] = 8'h27;
        check("uart10_lit_size", DW'(output_data_size), DW'(10));
        check("uart10_lit_data", output_data, exp);
        send_byte(8'h99, 1);
        check("done_ignores_size", DW'(output_data_size), DW'(10));
        check("done_holds", DW'(done), DW'(1));
        do_ack(1'b0);
        check_idle("uart10_ack");

`ifdef UART_FRAME_ASSEMBLER_TIMEOUT_EN
        b.delete();
        for (int k = 1; k <= 10; k++) b.push_back(8'(k));
        ble_side = 1'b0;
        foreach (b[i]) send_byte(b[i], 1);
        repeat (TMO - 5) @(negedge clk);
        check("tmo_early", DW'(error), DW'(0));
        waited = 0;
        while (error !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("tmo_error", DW'(error), DW'(1));
        check("tmo_code", DW'(error_code), DW'(2'b01));
        check("tmo_size", DW'(output_data_size), DW'(10));
        do_ack(1'b0);
        check_idle("tmo_ack");
`else
        b.delete();
        for (int k = 1; k <= 10; k++) b.push_back(8'(k));
        ble_side = 1'b0;
        foreach (b[i]) send_byte(b[i], 1);
        repeat (TMO + 50) @(negedge clk);
        check("notmo_error", DW'(error), DW'(0));
        check("notmo_size", DW'(output_data_size), DW'(10));
        send_byte(8'hBE, 1);
        send_byte(8'hEF, 1);
        check("notmo_done", DW'(done), DW'(1));
        do_ack(1'b0);
        check_idle("notmo_ack");
`endif

        b.delete();
        for (int k = 1; k <= 128; k++) b.push_back(8'(k));
        b.push_back(8'hBE);
        b.push_back(8'hEF);
        run_frame("max128", 1'b0, b, 1'b0);
        check("max128_lit_size", DW'(output_data_size), DW'(128));
        do_ack(1'b0);
        check_idle("max128_ack");

        b.delete();
        for (int k = 1; k <= 129; k++) b.push_back(8'(k));
        run_frame("ovf129", 1'b0, b, 1'b0);
        check("ovf129_lit_code", DW'(error_code), DW'(2'b10));
        do_ack(1'b0);
        check_idle("ovf129_ack");

        b.delete();
        repeat (10) b.push_back(8'h27);
        b.push_back(8'hBE);
        b.push_back(8'hEF);
        b.push_back(8'h0D);
        run_frame("ble12", 1'b1, b, 1'b0);
        check("ble12_lit_size", DW'(output_data_size), DW'(12));
        check("ble12_lit_b10", DW'(output_data[8*10 +: 8]), DW'(8'hBE));
        check("ble12_lit_b11", DW'(output_data[8*11 +: 8]), DW'(8'hEF));
        do_ack(1'b0);

        b.delete();
        b.push_back(8'h41); b.push_back(8'hBE); b.push_back(8'h42);
        b.push_back(8'hBE); b.push_back(8'hEF);
        run_frame("falseterm", 1'b0, b, 1'b0);
        check("falseterm_lit", DW'(output_data[23:0]), DW'(24'h42BE41));
        do_ack(1'b0);

        ble_side = 1'b0;
        for (int k = 0; k < 5; k++) send_byte(8'h60 + 8'(k), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("midreset");
        b.delete();
        b.push_back(8'h55); b.push_back(8'hBE); b.push_back(8'hEF);
        run_frame("postreset", 1'b0, b, 1'b0);
        check("postreset_lit_size", DW'(output_data_size), DW'(1));
        do_ack(1'b1);
        check_idle("ackprio");
        b.delete();
        b.push_back(8'hBE); b.push_back(8'hEF);
        run_frame("ackprio_next", 1'b0, b, 1'b0);
        do_ack(1'b0);

        ble_side = 1'b0;
        send_byte(8'h11, 4);
        b.delete();
        b.push_back(8'hBE); b.push_back(8'hEF);
        foreach (b[i]) send_byte(b[i], 1);
        check("held_strobe_size", DW'(output_data_size), DW'(1));
        check("held_strobe_b0", DW'(output_data[7:0]), DW'(8'h11));
        do_ack(1'b0);

        for (int f = 0; f < 40; f++) begin
            m   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(125, 134) : $urandom_range(0, 20);
            sp  = (len > 100) ? 3 : 25;
            b.delete();
            for (int i = 0; i < len; i++) b.push_back(rand_byte(sp));
            if (m) begin
                b.push_back(8'h0D);
            end else begin
                b.push_back(8'hBE);
                b.push_back(8'hEF);
            end
            run_frame($sformatf("rnd%0d", f), m, b, 1'b1);
            do_ack(1'($urandom_range(0, 1)));
            check_idle($sformatf("rnd%0d_ack", f));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_assembler.md
UART_FRAME_ASSEMBLER -- requirements
Module: uart_frame_assembler

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 128, max payload bytes per frame (>=2).
REQ-002 SHALL have parameter TIMEOUT, default 1026, idle clocks after last accepted byte before timeout error.
REQ-003 SHALL have localparam SIZE_W = $clog2(MAX_BYTES+1), width of size output.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port input_data  input  8  byte offered with accumulate.
REQ-007 SHALL have port accumulate  input  1  byte strobe; one byte per rising edge of this level.
REQ-008 SHALL have port ble_side  input  1  mode: 0 = UART terminator 0xBE 0xEF, 1 = BLE terminator 0x0D.
REQ-009 SHALL have port ack  input  1  consumer release of done/error frame.
REQ-010 SHALL have port output_data  output  8*MAX_BYTES  payload; byte k at bits [8k+7:8k], unused bytes zero.
REQ-011 SHALL have port output_data_size  output  SIZE_W  payload byte count, terminator excluded.
REQ-012 SHALL have ports done  output  1, error  output  1, error_code  output  2 (00 none, 01 timeout, 10 overflow).

Function
REQ-013 SHALL register accumulate each clk and accept a byte only on the cycle where accumulate=1 and previous sample=0; a held-high strobe accepts once.
REQ-014 SHALL implement states IDLE, ACCUM, PEND_BE, DONE, ERROR.
REQ-015 SHALL, on first accepted byte in IDLE, latch ble_side as frame mode; ble_side changes mid-frame SHALL have no effect until next IDLE.
REQ-016 SHALL, in UART mode, on byte 0xBE not store it and enter PEND_BE.
REQ-017 SHALL, in PEND_BE, on 0xEF enter DONE; on 0xBE store one held 0xBE and stay PEND_BE; on any other byte store 0xBE and that byte in the same cycle and return to ACCUM.
REQ-018 SHALL, in BLE mode, on byte 0x0D enter DONE without storing it; 0xBE/0xEF are ordinary payload in BLE mode.
REQ-019 SHALL store ordinary bytes at index output_data_size and increment size the same cycle.
REQ-020 SHALL enter ERROR with code 10 when an accepted byte would make stored count exceed MAX_BYTES; terminator bytes never count toward the limit (128 payload + 0xBE 0xEF is legal).
REQ-021 SHALL count clocks since last accepted byte in ACCUM/PEND_BE; when count equals TIMEOUT, enter ERROR with code 01; no timeout in IDLE/DONE/ERROR.
REQ-022 SHALL assert done exactly while in DONE and error exactly while in ERROR, registered, one cycle after the deciding byte edge.
REQ-023 SHALL hold output_data, output_data_size, error_code stable in DONE/ERROR and ignore accumulate there.
REQ-024 SHALL, on ack in DONE or ERROR, return to IDLE next cycle with data, size, error_code cleared; ack in other states SHALL be ignored.
REQ-025 SHALL give ack priority over a simultaneous accumulate edge; that byte is dropped.
REQ-026 SHALL, when timeout expiry and an accepted byte coincide, accept the byte and restart the timeout count.

Reset
REQ-027 SHALL, on reset=1 at clk edge, enter IDLE; output_data=0, output_data_size=0, done=0, error=0, error_code=00, timeout counter=0, strobe history=0.
REQ-028 SHALL give reset priority over all inputs, including mid-frame and in DONE/ERROR.

Configuration
REQ-029 SHALL compile timeout logic only when macro UART_FRAME_ASSEMBLER_TIMEOUT_EN is defined.
REQ-030 SHALL, without UART_FRAME_ASSEMBLER_TIMEOUT_EN, omit counter entirely, never produce code 01, and wait indefinitely in ACCUM/PEND_BE.

Verification (MAX_BYTES=128, TIMEOUT=1026, macro defined)
REQ-031 SHALL test UART: 10x 0x27 then 0xBE 0xEF -> done=1, size=10, bytes 0..9=0x27, byte10=0.
REQ-032 SHALL test timeout: bytes 0x01..0x0A then idle 1026 clks -> error=1, code=01, size=10; ack -> IDLE, all zero.
REQ-033 SHALL test max: 0x01..0x80 (128 bytes) then 0xBE 0xEF -> done=1, size=128; 129th payload byte instead -> error=1, code=10.
REQ-034 SHALL test BLE: ble_side=1, 10x 0x27, 0xBE, 0xEF, 0x0D -> done=1, size=12, byte10=0xBE, byte11=0xEF.
REQ-035 SHALL test false terminator: UART 0x41 0xBE 0x42 0xBE 0xEF -> size=3, bytes 0x41 0xBE 0x42.
REQ-036 SHALL test reset mid-frame after 5 bytes -> all outputs zero next cycle; new frame 0x55 0xBE 0xEF -> size=1.
